// File: rtl/serial_rx.sv
// 8N1 UART receiver that assembles NUM_BYTES consecutive bytes, LSB-first, into one
// 162-bit cube-state word and strobes data_valid when the last byte lands.
module serial_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 21,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_pin,
    output logic [161:0] data,
    output logic         data_valid,
    output logic         busy,
    output logic         framing_error,
    output logic [2:0]   state
);

    localparam int          DATA_W         = 162;
    localparam int          CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int          BC_W           = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int          TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int          TMR_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FULL_SLOTS     = NUM_BYTES - 1;
    localparam int          LAST_W         = DATA_W - (NUM_BYTES - 1) * 8;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [BC_W-1:0]   r_byte_count;
    logic [TMR_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_data;
    logic              r_data_valid;
    logic              r_framing_error;

    logic              w_rx;
    state_t            w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [2:0]        w_bit_next;
    logic [7:0]        w_shift_next;
    logic [BC_W-1:0]   w_bc_next;
    logic [TMR_W-1:0]  w_timer_next;
    logic [DATA_W-1:0] w_buf_next;
    logic              w_load_data;
    logic              w_dv_next;
    logic              w_fe_next;

    assign w_rx = r_sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit           <= '0;
            r_shift         <= '0;
            r_byte_count    <= '0;
            r_timer         <= '0;
            r_buf           <= '0;
            r_data          <= '0;
            r_data_valid    <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_sync1         <= rx_pin;
            r_sync2         <= r_sync1;
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_bit           <= w_bit_next;
            r_shift         <= w_shift_next;
            r_byte_count    <= w_bc_next;
            r_timer         <= w_timer_next;
            r_buf           <= w_buf_next;
            r_data_valid    <= w_dv_next;
            r_framing_error <= w_fe_next;
            if (w_load_data) begin
                r_data <= w_buf_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_bc_next    = r_byte_count;
        w_timer_next = r_timer;
        w_buf_next   = r_buf;
        w_load_data  = 1'b0;
        w_dv_next    = 1'b0;
        w_fe_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A start edge outranks a simultaneous timeout, keeping the partial packet.
                if (!w_rx) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end else if (r_byte_count != '0) begin
                    if (r_timer == TMR_MAX) begin
                        w_bc_next    = '0;
                        w_timer_next = '0;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
            end

            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next = '0;
                    if (!w_rx) begin
                        w_state_next = S_DATA;
                        w_bit_next   = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_timer_next = '0;
                    if (w_rx) begin
                        for (int unsigned k = 0; k < FULL_SLOTS; k++) begin
                            if (r_byte_count == BC_W'(k)) begin
                                w_buf_next[k*8 +: 8] = r_shift;
                            end
                        end
                        // The final slot only feeds the top LAST_W bits of the word.
                        if (r_byte_count == BC_LAST) begin
                            w_buf_next[DATA_W-1 -: LAST_W] = r_shift[LAST_W-1:0];
                            w_load_data = 1'b1;
                            w_dv_next   = 1'b1;
                            w_bc_next   = '0;
                        end else begin
                            w_bc_next = r_byte_count + 1'b1;
                        end
                        w_state_next = S_IDLE;
                    end else begin
                        w_fe_next    = 1'b1;
                        w_bc_next    = '0;
                        w_state_next = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                if (w_rx) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign data          = r_data;
    assign data_valid    = r_data_valid;
    assign framing_error = r_framing_error;
    assign busy          = (r_state != S_IDLE) || (r_byte_count != '0);
    assign state         = r_state;

endmodule

// File: doc/serial_rx.md
# serial_rx

UART receiver and packet assembler that is the receiving counterpart of the team's 21-byte cube-state transmitter. It accepts 8N1 bytes on `rx_pin` and packs 21 consecutive bytes LSB-first into a 162-bit word (54 facelets × 3 bits). It presents each complete word on `data` with a one-cycle `data_valid` strobe. It sits between the board's serial input pin and the solver/state logic, which consumes whole cube states.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit period (100 MHz / 115200); must be even and ≥ 8.
- `NUM_BYTES`, 21, bytes per packet.
- `TIMEOUT_BITS`, 20, idle bit-periods after which a partial packet is discarded.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_pin`  in  1  asynchronous serial line; idle high.
- `data`  out  162  last complete packet; byte k occupies bits [8k+7:8k], and byte 20 supplies bits 161:160 only.
- `data_valid`  out  1  one-cycle pulse when `data` updates.
- `busy`  out  1  high while any packet byte has been accepted or a frame is in progress.
- `framing_error`  out  1  one-cycle pulse on a bad stop bit.
- `state`  out  3  current FSM state (debug).

## Operation
- `rx_pin` passes through a two-flop synchronizer (both flops reset to 1); the FSM sees only the synced `rx`.
- FSM states: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4. The cycle counter `cnt` is 0..CLKS_PER_BIT-1, the bit index is 0..7, and `byte_count` is 0..NUM_BYTES-1.
- IDLE:
  - When `rx`=0, go to START with `cnt`=0.
  - When `byte_count`≠0, the idle timer increments each cycle.
  - When the idle timer reaches TIMEOUT_BITS×CLKS_PER_BIT, clear `byte_count` and the timer. No strobe is issued.
- START:
  - At `cnt`=CLKS_PER_BIT/2−1 (mid start bit), if `rx`=0 go to DATA with `cnt`=0 and bit index 0.
  - Otherwise it was a glitch: return to IDLE, leaving `byte_count` unchanged.
- DATA: at `cnt`=CLKS_PER_BIT−1, sample `rx` into the shift register. The shift register shifts right and inserts at bit 7, so the first bit received is the LSB. After bit index 7 is sampled, go to STOP.
- STOP: at `cnt`=CLKS_PER_BIT−1, sample `rx`.
  - If 1: write the byte into packet buffer slot `byte_count`.
  - If `byte_count`=NUM_BYTES−1: copy the buffer (including this byte) to `data`, pulse `data_valid`, and set `byte_count`=0.
  - Otherwise increment `byte_count`.
  - In both cases go to IDLE and clear the idle timer.
  - If 0: pulse `framing_error`, clear `byte_count` (the whole partial packet is dropped), and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx`=1, then go to IDLE. A break or stuck-low line never starts a frame.
- `busy` = (state≠IDLE) or (`byte_count`≠0).
- Bits 167:162 of the assembled buffer are discarded; the transmitter sends zeros there, and they are never checked.
- `data` holds its value until the next complete packet; partial packets never modify it.

## Timing
- Reset values:
  - `data`=0, `data_valid`=0, `framing_error`=0, `busy`=0, `state`=IDLE.
  - `byte_count`=0, `cnt`=0, idle timer=0, synchronizer flops=1.
- Reset mid-frame or mid-packet discards everything in flight; `data` still returns to 0.
- The sample point is the bit centre plus the fixed 2-cycle synchronizer delay.
- `data_valid` and `framing_error` are registered. They assert on the edge after the STOP-sample condition and are high for exactly one cycle.
- `data` changes on the same edge that `data_valid` rises.
- Latency from the line's stop-bit centre to `data_valid` is 3 cycles (2 synchronizer + 1 register).
- A new start bit is accepted in the first cycle the FSM is in IDLE. Back-to-back bytes with zero idle time between them are supported.
- If the timeout and a falling `rx` occur in the same cycle, the start bit wins: go to START, and `byte_count` is not cleared.
- No back-pressure: the consumer must capture `data` before the next packet completes, which is at least 210 bit periods later.

## Test plan
Use `CLKS_PER_BIT`=16 for all scenarios.

- Reset hold 5 cycles, line high -> all outputs 0, `state`=0, and no `data_valid` for 1000 cycles.
- Send 21 bytes 0x01,0x02,…,0x15 back-to-back -> exactly one `data_valid` pulse.
  - `data[7:0]`=0x01 and `data[15:8]`=0x02.
  - `data[161:160]`=2'b01, the low bits of 0x15.
  - The pulse arrives 3 cycles after the last stop-bit centre.
- 4-cycle low glitch on `rx` while idle -> returns to IDLE from START, no byte accepted, and `byte_count` unchanged.
- Send 5 bytes, then a frame with stop bit 0, then 21 good bytes 0xFF:
  - One `framing_error` pulse.
  - The FSM waits in state 4 until the line goes high.
  - Exactly one `data_valid`, with `data`=all ones (162 bits).
- Send 10 bytes, idle 20×16 cycles, then 21 bytes of 0xA5 -> the partial packet is dropped, and a single `data_valid` has `data[7:0]`=0xA5 and `data[161:160]`=2'b01.
- Assert `reset` for 1 cycle during byte 12 of a packet, then send a full packet -> `data` is 0 immediately after reset, and the next `data_valid` carries only the new packet.
